// File: rtl/color_compositor_if.sv
// Pixel bus between the layer renderers and the final-colour stage.
// The renderer side drives layers, position and flash requests; the compositor returns the pixel.
interface color_compositor_if #(
  parameter int COLOR_W = 3,
  parameter int LAYERS  = 4
);
  logic [LAYERS*COLOR_W-1:0] colorLayers;
  logic [COLOR_W-1:0]        bgColor;
  logic [9:0]                hPos;
  logic [9:0]                vPos;
  logic                      flash_req;
  logic [COLOR_W-1:0]        color;
  logic                      flash_active;

  modport master (
    output colorLayers, bgColor, hPos, vPos, flash_req,
    input  color, flash_active
  );

  modport slave (
    input  colorLayers, bgColor, hPos, vPos, flash_req,
    output color, flash_active
  );
endinterface

// File: rtl/color_compositor.sv
// Final-colour stage: priority layer merge with colour key, background fill, blanking
// and a frame-counted full-screen invert flash, with a fixed two-cycle latency.
module color_compositor #(
  parameter int COLOR_W       = 3,
  parameter int LAYERS        = 4,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int BLANK_COLOR   = 7,
  parameter int TRANSP_COLOR  = 0,
  parameter int FLASH_FRAMES  = 8
) (
  input  logic               clk,
  input  logic               rst,
  color_compositor_if.slave  bus
);

  localparam int CNT_W = (FLASH_FRAMES > 0) ? $clog2(FLASH_FRAMES + 1) : 1;
  localparam logic [10:0]        W_LIM = 11'(SCREEN_WIDTH);
  localparam logic [10:0]        H_LIM = 11'(SCREEN_HEIGHT);
  localparam logic [COLOR_W-1:0] BLANK = COLOR_W'(BLANK_COLOR);
  localparam logic [COLOR_W-1:0] TRANSP = COLOR_W'(TRANSP_COLOR);

  logic [LAYERS*COLOR_W-1:0] r_layers;
  logic [COLOR_W-1:0]        r_bg;
  logic                      r_visible;
  logic                      r_flash;
  logic [COLOR_W-1:0]        r_color;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_flash_active;

  logic                      w_visible;
  logic                      w_frame_tick;
  logic [CNT_W-1:0]          w_cnt_next;
  logic [COLOR_W-1:0]        w_pix;
  logic [COLOR_W-1:0]        w_color;

  assign w_visible    = ({1'b0, bus.hPos} < W_LIM) && ({1'b0, bus.vPos} < H_LIM);
  assign w_frame_tick = (bus.hPos == 10'd0) && (bus.vPos == 10'd0);

  // A request reloads even mid-flash and wins over a coincident frame tick.
  always_comb begin
    // NOTE: default first so no path leaves the signal unassigned and infers a latch.
    w_cnt_next = r_cnt;
    if (FLASH_FRAMES != 0 && bus.flash_req)
      w_cnt_next = CNT_W'(FLASH_FRAMES);
    else if (w_frame_tick && r_cnt != '0)
      w_cnt_next = r_cnt - 1'b1;
  end

  // Scan from lowest priority upward so the lowest-index opaque layer ends up winning.
  always_comb begin
    w_pix = r_bg;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (r_layers[i*COLOR_W +: COLOR_W] != TRANSP)
        w_pix = r_layers[i*COLOR_W +: COLOR_W];
    end
  end

  always_comb begin
    w_color = w_pix;
    if (!r_visible)
      w_color = BLANK;
    else if (r_flash)
      w_color = ~w_pix;
  end

  // NOTE: pure datapath registers carry no reset; the cleared visible flag masks them.
  always_ff @(posedge clk) begin
    r_layers <= bus.colorLayers;
    r_bg     <= bus.bgColor;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_visible      <= 1'b0;
      r_flash        <= 1'b0;
      r_cnt          <= '0;
      r_flash_active <= 1'b0;
      r_color        <= BLANK;
    end else begin
      r_visible      <= w_visible;
      r_flash        <= r_flash_active;
      r_cnt          <= w_cnt_next;
      r_flash_active <= (w_cnt_next != '0);
      r_color        <= w_color;
    end
  end

  assign bus.color        = r_color;
  assign bus.flash_active = r_flash_active;

endmodule

// File: tb/tb_color_compositor.sv
// Self-checking bench for color_compositor: directed scenarios followed by random pixels,
// compared each cycle against a behavioural model of the pixel rules and flash timing.
module tb_color_compositor;

  localparam int FF = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  color_compositor_if #(.COLOR_W(3), .LAYERS(4)) bus ();

  color_compositor #(
    .COLOR_W(3), .LAYERS(4), .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480),
    .BLANK_COLOR(7), .TRANSP_COLOR(0), .FLASH_FRAMES(FF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int m_cnt    = 0;          // frames of flash left
  logic [2:0] m_prev = 3'd7; // expected output for the previous cycle's pixel

  function automatic logic [2:0] ref_pix(input logic [11:0] l, input logic [2:0] bg,
                                         input int h, input int v, input bit fl);
    logic [2:0] layer_q[$];
    logic [2:0] p;
    if (!(h < 640 && v < 480)) return 3'd7;
    for (int i = 0; i < 4; i++) layer_q.push_back(l[i*3 +: 3]);
    p = bg;
    while (layer_q.size() > 0) begin
      logic [2:0] c;
      c = layer_q.pop_front();
      if (c != 3'd0) begin
        p = c;
        break;
      end
    end
    return fl ? ~p : p;
  endfunction

  task automatic cycle(input bit r, input logic [11:0] l, input logic [2:0] bg,
                       input int h, input int v, input bit req, input string tag);
    logic [2:0] this_px;
    logic [2:0] exp_color;
    bit exp_fa;
    @(negedge clk);
    rst             = r;
    bus.colorLayers = l;
    bus.bgColor     = bg;
    bus.hPos        = 10'(h);
    bus.vPos        = 10'(v);
    bus.flash_req   = req;
    this_px   = r ? 3'd7 : ref_pix(l, bg, h, v, m_cnt != 0);
    exp_color = r ? 3'd7 : m_prev;
    if (r)                         m_cnt = 0;
    else if (req && FF != 0)       m_cnt = FF;
    else if (h == 0 && v == 0 && m_cnt > 0) m_cnt = m_cnt - 1;
    exp_fa = (m_cnt != 0);
    @(posedge clk);
    #1;
    n_checks++;
    assert (bus.color === exp_color) else begin
      n_errors++;
      $error("FAIL %s color: got %0d expected %0d", tag, bus.color, exp_color);
    end
    n_checks++;
    assert (bus.flash_active === exp_fa) else begin
      n_errors++;
      $error("FAIL %s flash_active: got %0b expected %0b", tag, bus.flash_active, exp_fa);
    end
    m_prev = this_px;
  endtask

  function automatic logic [11:0] pack(input int l0, input int l1, input int l2, input int l3);
    return {3'(l3), 3'(l2), 3'(l1), 3'(l0)};
  endfunction

  initial begin
    bus.colorLayers = '0;
    bus.bgColor     = '0;
    bus.hPos        = '0;
    bus.vPos        = '0;
    bus.flash_req   = 1'b0;

    // Reset with arbitrary inputs, then release.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 12'($urandom), 3'($urandom), 100, 100, 1'($urandom), "reset");
    cycle(1'b0, pack(0, 5, 3, 0), 3'd2, 100, 100, 1'b0, "post_rst0");
    cycle(1'b0, pack(0, 0, 0, 0), 3'd2, 100, 100, 1'b0, "post_rst1");

    // Priority, transparency and background.
    cycle(1'b0, pack(0, 5, 3, 0), 3'd2, 100, 100, 1'b0, "prio");
    cycle(1'b0, pack(0, 0, 0, 6), 3'd2, 200, 50, 1'b0, "last_layer");
    cycle(1'b0, pack(3, 5, 1, 6), 3'd0, 300, 300, 1'b0, "top_layer");
    cycle(1'b0, pack(0, 0, 0, 0), 3'd0, 1, 1, 1'b0, "bg_zero");

    // Blanking boundaries.
    cycle(1'b0, pack(4, 0, 0, 0), 3'd2, 639, 479, 1'b0, "edge_vis");
    cycle(1'b0, pack(4, 0, 0, 0), 3'd2, 640, 10, 1'b0, "h_blank");
    cycle(1'b0, pack(4, 0, 0, 0), 3'd2, 10, 480, 1'b0, "v_blank");
    cycle(1'b0, pack(4, 0, 0, 0), 3'd2, 1023, 1023, 1'b0, "max_blank");

    // Flash started mid-frame, lasting two frame ticks.
    cycle(1'b0, pack(1, 0, 0, 0), 3'd2, 5, 5, 1'b1, "flash_req");
    for (int i = 0; i < 4; i++)
      cycle(1'b0, pack(1, 0, 0, 0), 3'd2, 6 + i, 5, 1'b0, "flash_on");
    cycle(1'b0, pack(1, 0, 0, 0), 3'd2, 700, 5, 1'b0, "flash_blank");
    cycle(1'b0, pack(1, 0, 0, 0), 3'd2, 0, 0, 1'b0, "tick1");
    cycle(1'b0, pack(1, 0, 0, 0), 3'd2, 1, 0, 1'b0, "after_tick1");
    cycle(1'b0, pack(1, 0, 0, 0), 3'd2, 0, 0, 1'b0, "tick2");
    for (int i = 0; i < 3; i++)
      cycle(1'b0, pack(1, 0, 0, 0), 3'd2, 1 + i, 0, 1'b0, "flash_off");

    // Retrigger coincident with a tick, then retrigger after one tick.
    cycle(1'b0, pack(0, 2, 0, 0), 3'd2, 50, 50, 1'b1, "re_req");
    cycle(1'b0, pack(0, 2, 0, 0), 3'd2, 0, 0, 1'b0, "re_tick");
    cycle(1'b0, pack(0, 2, 0, 0), 3'd2, 0, 0, 1'b1, "req_on_tick");
    cycle(1'b0, pack(0, 2, 0, 0), 3'd2, 0, 0, 1'b0, "re_tick_a");
    cycle(1'b0, pack(0, 2, 0, 0), 3'd2, 60, 60, 1'b1, "req_again");
    cycle(1'b0, pack(0, 2, 0, 0), 3'd2, 0, 0, 1'b0, "re_tick_b");
    cycle(1'b0, pack(0, 2, 0, 0), 3'd2, 61, 60, 1'b0, "still_on");
    cycle(1'b0, pack(0, 2, 0, 0), 3'd2, 0, 0, 1'b0, "re_tick_c");
    cycle(1'b0, pack(0, 2, 0, 0), 3'd2, 62, 60, 1'b0, "re_off");
    cycle(1'b0, pack(0, 2, 0, 0), 3'd2, 63, 60, 1'b0, "re_off2");

    // Reset during an active flash.
    cycle(1'b0, pack(5, 0, 0, 0), 3'd2, 20, 20, 1'b1, "mid_req");
    cycle(1'b0, pack(5, 0, 0, 0), 3'd2, 21, 20, 1'b0, "mid_on");
    cycle(1'b1, pack(5, 0, 0, 0), 3'd2, 22, 20, 1'b0, "mid_rst");
    for (int i = 0; i < 4; i++)
      cycle(1'b0, pack(5, 0, 0, 0), 3'd2, 23 + i, 20, 1'b0, "after_mid_rst");

    // Random pixels with occasional ticks, boundary coordinates, requests and resets.
    for (int i = 0; i < 500; i++) begin
      int h, v;
      int mode;
      logic [11:0] l;
      mode = int'($urandom_range(0, 9));
      if (mode == 0) begin
        h = 0; v = 0;
      end else if (mode == 1) begin
        h = 639 + int'($urandom_range(0, 1));
        v = 479 + int'($urandom_range(0, 1));
      end else begin
        h = int'($urandom_range(0, 700));
        v = int'($urandom_range(0, 520));
      end
      for (int k = 0; k < 4; k++)
        l[k*3 +: 3] = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom);
      cycle(($urandom_range(0, 49) == 0), l, 3'($urandom), h, v,
            ($urandom_range(0, 19) == 0), "random");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
